// File: rtl/lock_pkg.sv
// Shared definitions for the lock sequencer: default parameters, the controller
// state encoding, the press-event encoding and the strobe bundle.
package lock_pkg;

    localparam int DEF_PW_LEN         = 4;
    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_SLEEP_CYCLES   = 250000000;
    localparam int DEF_RESULT_TIMEOUT = 16;

    localparam int SYM_W  = 3;
    localparam int FAIL_W = 2;

    typedef enum logic [2:0] {
        ST_SET    = 3'd0,
        ST_LOCKED = 3'd1,
        ST_CHECK  = 3'd2,
        ST_OPEN   = 3'd3,
        ST_SLEEP  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        EV_NONE   = 2'd0,
        EV_STORE  = 2'd1,
        EV_INPUT  = 2'd2,
        EV_SUBMIT = 2'd3
    } event_e;

    typedef struct packed {
        logic store_value;
        logic input_value;
        logic compare;
        logic input_reset;
        logic sys_clear;
        logic end_sleep;
    } strobe_t;

    // Simultaneous presses collapse to a single event: submit > input > store.
    function automatic event_e pick_event(input logic store, input logic inp, input logic submit);
        event_e ev;
        ev = EV_NONE;
        if (submit) begin
            ev = EV_SUBMIT;
        end else if (inp) begin
            ev = EV_INPUT;
        end else if (store) begin
            ev = EV_STORE;
        end
        return ev;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// One press pulse is produced two clocks after the button is first sampled high.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic press_q, press_d;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        press_d = sync2_q & ~prev_q;
    end

    // NOTE: non-blocking assignments, so every flop samples its neighbour's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/lock_sequencer.sv
// Password lock controller: turns button press events and checker results into
// register strobes, tracks entered symbols and failures, and enforces a timed lockout.
module lock_sequencer #(
    parameter int PW_LEN         = lock_pkg::DEF_PW_LEN,
    parameter int MAX_FAILS      = lock_pkg::DEF_MAX_FAILS,
    parameter int SLEEP_CYCLES   = lock_pkg::DEF_SLEEP_CYCLES,
    parameter int RESULT_TIMEOUT = lock_pkg::DEF_RESULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       system_reset,
    input  logic       store_btn,
    input  logic       input_btn,
    input  logic       submit_btn,
    input  logic       correct_password,
    input  logic       incorrect_password,
    output logic       store_value,
    output logic       input_value,
    output logic       compare,
    output logic       input_reset,
    output logic       sys_clear,
    output logic       unlock,
    output logic       sleep,
    output logic       end_sleep,
    output logic [2:0] sym_count,
    output logic [1:0] fail_count
);

    import lock_pkg::*;

    // Both timers count 0..N-1, so ceil(log2(N)) bits never wrap.
    localparam int SLEEP_W = (SLEEP_CYCLES > 1) ? $clog2(SLEEP_CYCLES) : 1;
    localparam int CHECK_W = (RESULT_TIMEOUT > 1) ? $clog2(RESULT_TIMEOUT) : 1;

    localparam logic [SLEEP_W-1:0] SLEEP_LAST = SLEEP_W'(SLEEP_CYCLES - 1);
    localparam logic [CHECK_W-1:0] CHECK_LAST = CHECK_W'(RESULT_TIMEOUT - 1);
    localparam logic [SYM_W-1:0]   SYM_FULL   = SYM_W'(PW_LEN);
    localparam logic [FAIL_W-1:0]  FAIL_MAX   = FAIL_W'(MAX_FAILS);
    localparam logic [FAIL_W-1:0]  FAIL_LAST  = FAIL_W'(MAX_FAILS - 1);

    logic               store_press;
    logic               input_press;
    logic               submit_press;
    event_e             ev;
    logic               failure;

    state_e             state_q,     state_d;
    strobe_t            strb_q,      strb_d;
    logic [SYM_W-1:0]   sym_q,       sym_d;
    logic [FAIL_W-1:0]  fail_q,      fail_d;
    logic [SLEEP_W-1:0] sleep_tmr_q, sleep_tmr_d;
    logic [CHECK_W-1:0] check_tmr_q, check_tmr_d;
    logic               unlock_q,    unlock_d;
    logic               sleep_q,     sleep_d;

    btn_edge u_store_edge (
        .clk   (clk),
        .rst   (system_reset),
        .btn   (store_btn),
        .press (store_press)
    );

    btn_edge u_input_edge (
        .clk   (clk),
        .rst   (system_reset),
        .btn   (input_btn),
        .press (input_press)
    );

    btn_edge u_submit_edge (
        .clk   (clk),
        .rst   (system_reset),
        .btn   (submit_btn),
        .press (submit_press)
    );

    always_comb begin
        // NOTE: every signal gets its default before the case, so no path can infer a latch.
        state_d     = state_q;
        strb_d      = '0;
        sym_d       = sym_q;
        fail_d      = fail_q;
        sleep_tmr_d = '0;
        check_tmr_d = '0;
        failure     = 1'b0;
        ev          = pick_event(store_press, input_press, submit_press);

        case (state_q)
            ST_SET: begin
                if (ev == EV_STORE) begin
                    strb_d.store_value = 1'b1;
                    if (sym_q == SYM_FULL - 1'b1) begin
                        sym_d   = '0;
                        state_d = ST_LOCKED;
                    end else begin
                        sym_d = sym_q + 1'b1;
                    end
                end
            end

            ST_LOCKED: begin
                if (ev == EV_INPUT && sym_q < SYM_FULL) begin
                    strb_d.input_value = 1'b1;
                    sym_d              = sym_q + 1'b1;
                end else if (ev == EV_SUBMIT) begin
                    if (sym_q == SYM_FULL) begin
                        strb_d.compare = 1'b1;
                        state_d        = ST_CHECK;
                    end else begin
                        failure = 1'b1;
                    end
                end
            end

            // Press events are deliberately not looked at while a result is pending.
            ST_CHECK: begin
                if (correct_password && !incorrect_password) begin
                    strb_d.input_reset = 1'b1;
                    sym_d              = '0;
                    fail_d             = '0;
                    state_d            = ST_OPEN;
                end else if (incorrect_password || check_tmr_q == CHECK_LAST) begin
                    failure = 1'b1;
                end else begin
                    check_tmr_d = check_tmr_q + 1'b1;
                end
            end

            ST_OPEN: begin
                if (ev == EV_SUBMIT) begin
                    strb_d.input_reset = 1'b1;
                    state_d            = ST_LOCKED;
                end else if (ev == EV_STORE) begin
                    strb_d.sys_clear = 1'b1;
                    sym_d            = '0;
                    state_d          = ST_SET;
                end
            end

            ST_SLEEP: begin
                if (sleep_tmr_q == SLEEP_LAST) begin
                    strb_d.end_sleep = 1'b1;
                    fail_d           = '0;
                    state_d          = ST_LOCKED;
                end else begin
                    sleep_tmr_d = sleep_tmr_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_SET;
            end
        endcase

        // Short submit and every CHECK failure share one path; the count saturates.
        if (failure) begin
            strb_d.input_reset = 1'b1;
            sym_d              = '0;
            if (fail_q >= FAIL_LAST) begin
                fail_d  = FAIL_MAX;
                state_d = ST_SLEEP;
            end else begin
                fail_d  = fail_q + 1'b1;
                state_d = ST_LOCKED;
            end
        end

        unlock_d = (state_d == ST_OPEN);
        sleep_d  = (state_d == ST_SLEEP);
    end

    always_ff @(posedge clk or posedge system_reset) begin
        if (system_reset) begin
            state_q     <= ST_SET;
            strb_q      <= '0;
            sym_q       <= '0;
            fail_q      <= '0;
            sleep_tmr_q <= '0;
            check_tmr_q <= '0;
            unlock_q    <= 1'b0;
            sleep_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            strb_q      <= strb_d;
            sym_q       <= sym_d;
            fail_q      <= fail_d;
            sleep_tmr_q <= sleep_tmr_d;
            check_tmr_q <= check_tmr_d;
            unlock_q    <= unlock_d;
            sleep_q     <= sleep_d;
        end
    end

    assign store_value = strb_q.store_value;
    assign input_value = strb_q.input_value;
    assign compare     = strb_q.compare;
    assign input_reset = strb_q.input_reset;
    assign sys_clear   = strb_q.sys_clear;
    assign end_sleep   = strb_q.end_sleep;
    assign unlock      = unlock_q;
    assign sleep       = sleep_q;
    assign sym_count   = sym_q;
    assign fail_count  = fail_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: a directed press table, hand-written
// multi-cycle sequences, then random stimulus against a behavioural model.
module tb_lock_sequencer;

    localparam int PW     = 4;
    localparam int MAXF   = 3;
    localparam int SLEEPC = 20;
    localparam int RT     = 16;

    // Button masks {submit, input, store}; result masks {incorrect, correct}.
    localparam logic [2:0] B_ST = 3'b001;
    localparam logic [2:0] B_IN = 3'b010;
    localparam logic [2:0] B_SU = 3'b100;
    localparam logic [1:0] R_OK   = 2'b01;
    localparam logic [1:0] R_BAD  = 2'b10;
    localparam logic [1:0] R_BOTH = 2'b11;

    // Strobe masks {end_sleep, sys_clear, input_reset, compare, input_value, store_value}.
    localparam logic [5:0] S_ST  = 6'b000001;
    localparam logic [5:0] S_IV  = 6'b000010;
    localparam logic [5:0] S_CMP = 6'b000100;
    localparam logic [5:0] S_IR  = 6'b001000;
    localparam logic [5:0] S_SC  = 6'b010000;
    localparam logic [5:0] S_ES  = 6'b100000;
    localparam logic [5:0] S_NO  = 6'b000000;

    logic       clk;
    logic       system_reset;
    logic       store_btn, input_btn, submit_btn;
    logic       correct_password, incorrect_password;
    logic       store_value, input_value, compare, input_reset, sys_clear;
    logic       unlock, sleep, end_sleep;
    logic [2:0] sym_count;
    logic [1:0] fail_count;

    lock_sequencer #(
        .PW_LEN         (PW),
        .MAX_FAILS      (MAXF),
        .SLEEP_CYCLES   (SLEEPC),
        .RESULT_TIMEOUT (RT)
    ) dut (
        .clk                (clk),
        .system_reset       (system_reset),
        .store_btn          (store_btn),
        .input_btn          (input_btn),
        .submit_btn         (submit_btn),
        .correct_password   (correct_password),
        .incorrect_password (incorrect_password),
        .store_value        (store_value),
        .input_value        (input_value),
        .compare            (compare),
        .input_reset        (input_reset),
        .sys_clear          (sys_clear),
        .unlock             (unlock),
        .sleep              (sleep),
        .end_sleep          (end_sleep),
        .sym_count          (sym_count),
        .fail_count         (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] strobes();
        return {end_sleep, sys_clear, input_reset, compare, input_value, store_value};
    endfunction

    function automatic logic [6:0] levels();
        return {unlock, sleep, sym_count, fail_count};
    endfunction

    // ---------------- directed press table ----------------
    typedef struct {
        string      nm;
        logic [2:0] b;
        logic [1:0] r;
        logic [5:0] e3;
        logic [5:0] e4;
        logic       u;
        logic       s;
        logic [2:0] sym;
        logic [1:0] f;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input logic [2:0] b, input logic [1:0] r,
                       input logic [5:0] e3, input logic [5:0] e4, input logic u,
                       input logic s, input logic [2:0] sym, input logic [1:0] f);
        vec_t v;
        v.nm = nm; v.b = b; v.r = r; v.e3 = e3; v.e4 = e4;
        v.u = u; v.s = s; v.sym = sym; v.f = f;
        tbl.push_back(v);
    endtask

    // A press holds the buttons for two samples. Its strobe must appear exactly
    // 3 cycles after the first sample; a result is driven for the following sample,
    // so a CHECK outcome strobe lands at offset 4.
    task automatic press(input string nm, input logic [2:0] b, input logic [1:0] r,
                         input logic [5:0] e3, input logic [5:0] e4, input logic u,
                         input logic s, input logic [2:0] sym, input logic [1:0] f);
        logic [5:0] stray;
        stray = '0;
        {submit_btn, input_btn, store_btn} = b;
        for (int o = 0; o <= 6; o++) begin
            step();
            if (o == 1) {submit_btn, input_btn, store_btn} = 3'b000;
            if (o == 3) begin
                check({nm, " strobe@3"}, 16'(strobes()), 16'(e3));
                {incorrect_password, correct_password} = r;
            end else if (o == 4) begin
                check({nm, " strobe@4"}, 16'(strobes()), 16'(e4));
                {incorrect_password, correct_password} = 2'b00;
            end else begin
                stray |= strobes();
            end
        end
        check({nm, " stray strobes"}, 16'(stray), 16'(S_NO));
        check({nm, " unlock/sleep/sym/fail"}, 16'(levels()), 16'({u, s, sym, f}));
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int M_SET = 0, M_LOCKED = 1, M_CHECK = 2, M_OPEN = 3, M_SLEEP = 4;

    int         m_mode, m_sym, m_fail, m_wait, m_left;
    logic [2:0] hist [5];
    logic [5:0] m_str;

    task automatic model_reset();
        m_mode = M_SET; m_sym = 0; m_fail = 0; m_wait = 0; m_left = 0; m_str = '0;
        for (int i = 0; i < 5; i++) hist[i] = '0;
    endtask

    task automatic model_fail();
        m_str  = S_IR;
        m_sym  = 0;
        m_fail = (m_fail + 1 > MAXF) ? MAXF : m_fail + 1;
        if (m_fail == MAXF) begin
            m_mode = M_SLEEP;
            m_left = SLEEPC;
        end else begin
            m_mode = M_LOCKED;
        end
    endtask

    // One clock edge: b is the button level sampled at this edge, r the results.
    // A press acts 3 edges after the edge where its button was first seen high.
    task automatic model_edge(input logic [2:0] b, input logic [1:0] r);
        logic [2:0] ev;
        for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = b;
        ev = hist[3] & ~hist[4];
        if (ev[2]) ev = B_SU;
        else if (ev[1]) ev = B_IN;
        m_str = '0;
        case (m_mode)
            M_SET: begin
                if (ev == B_ST) begin
                    m_str = S_ST;
                    m_sym++;
                    if (m_sym == PW) begin
                        m_sym  = 0;
                        m_mode = M_LOCKED;
                    end
                end
            end
            M_LOCKED: begin
                if (ev == B_IN && m_sym < PW) begin
                    m_str = S_IV;
                    m_sym++;
                end else if (ev == B_SU) begin
                    if (m_sym == PW) begin
                        m_str  = S_CMP;
                        m_mode = M_CHECK;
                        m_wait = 0;
                    end else begin
                        model_fail();
                    end
                end
            end
            M_CHECK: begin
                if (r == R_OK) begin
                    m_str = S_IR; m_sym = 0; m_fail = 0; m_mode = M_OPEN;
                end else if (r != 2'b00) begin
                    model_fail();
                end else begin
                    m_wait++;
                    if (m_wait == RT) model_fail();
                end
            end
            M_OPEN: begin
                if (ev == B_SU) begin
                    m_str = S_IR; m_mode = M_LOCKED;
                end else if (ev == B_ST) begin
                    m_str = S_SC; m_sym = 0; m_mode = M_SET;
                end
            end
            M_SLEEP: begin
                m_left--;
                if (m_left == 0) begin
                    m_str = S_ES; m_fail = 0; m_mode = M_LOCKED;
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ir_at, es_at, sleep_n, iv_n, fail_mid, es_lv, to_at;
        logic [2:0] rb;
        logic [1:0] rr;

        system_reset = 1'b1;
        {store_btn, input_btn, submit_btn} = 3'b000;
        {correct_password, incorrect_password} = 2'b00;
        step();
        step();
        check("reset strobes", 16'(strobes()), 16'(S_NO));
        check("reset levels", 16'(levels()), 16'(7'd0));
        system_reset = 1'b0;

        // Table: store a password, enter, submit, open, clear, re-store, fail twice.
        for (int i = 1; i <= 3; i++) add("store", B_ST, 0, S_ST, S_NO, 0, 0, 3'(i), 0);
        add("store 4th -> LOCKED", B_ST, 0, S_ST, S_NO, 0, 0, 0, 0);
        add("input", B_IN, 0, S_IV, S_NO, 0, 0, 1, 0);
        add("input", B_IN, 0, S_IV, S_NO, 0, 0, 2, 0);
        add("short submit", B_SU, 0, S_IR, S_NO, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) add("input", B_IN, 0, S_IV, S_NO, 0, 0, 3'(i), 1);
        add("5th input", B_IN, 0, S_NO, S_NO, 0, 0, 4, 1);
        add("submit correct", B_SU, R_OK, S_CMP, S_IR, 1, 0, 0, 0);
        add("open input", B_IN, 0, S_NO, S_NO, 1, 0, 0, 0);
        add("open store", B_ST, 0, S_SC, S_NO, 0, 0, 0, 0);
        add("set input", B_IN, 0, S_NO, S_NO, 0, 0, 0, 0);
        add("set submit", B_SU, 0, S_NO, S_NO, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) add("restore", B_ST, 0, S_ST, S_NO, 0, 0, 3'(i), 0);
        add("restore 4th", B_ST, 0, S_ST, S_NO, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) add("input", B_IN, 0, S_IV, S_NO, 0, 0, 3'(i), 0);
        add("submit correct 2", B_SU, R_OK, S_CMP, S_IR, 1, 0, 0, 0);
        add("open submit", B_SU, 0, S_IR, S_NO, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) add("input", B_IN, 0, S_IV, S_NO, 0, 0, 3'(i), 0);
        add("submit incorrect", B_SU, R_BAD, S_CMP, S_IR, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) add("input", B_IN, 0, S_IV, S_NO, 0, 0, 3'(i), 1);
        add("submit both results", B_SU, R_BOTH, S_CMP, S_IR, 0, 0, 0, 2);
        add("locked store", B_ST, 0, S_NO, S_NO, 0, 0, 0, 2);
        add("input", B_IN, 0, S_IV, S_NO, 0, 0, 1, 2);
        add("input+store", B_IN | B_ST, 0, S_IV, S_NO, 0, 0, 2, 2);

        foreach (tbl[i])
            press(tbl[i].nm, tbl[i].b, tbl[i].r, tbl[i].e3, tbl[i].e4,
                  tbl[i].u, tbl[i].s, tbl[i].sym, tbl[i].f);

        // Third failure: submit+input together at sym 2 -> submit wins -> SLEEP.
        ir_at = -1; es_at = -1; sleep_n = 0; iv_n = 0; fail_mid = -1; es_lv = -1;
        {submit_btn, input_btn} = 2'b11;
        for (int c = 0; c < 60; c++) begin
            step();
            if (c == 1) {submit_btn, input_btn} = 2'b00;
            if (input_value) iv_n++;
            if (input_reset && ir_at < 0) ir_at = c;
            if (sleep) sleep_n++;
            if (c == 10) fail_mid = int'(fail_count);
            if (end_sleep && es_at < 0) begin
                es_at = c;
                es_lv = int'({sleep, fail_count});
            end
        end
        check("priority: no input_value", 16'(iv_n), 16'd0);
        check("3rd failure input_reset offset", 16'(ir_at), 16'd3);
        check("fail_count during sleep", 16'(fail_mid), 16'd3);
        check("sleep duration", 16'(sleep_n), 16'(SLEEPC));
        check("end_sleep offset", 16'(es_at), 16'(3 + SLEEPC));
        check("sleep/fail at end_sleep", 16'(es_lv), 16'd0);

        // Compare with no result: failure after RT silent samples; presses in CHECK discarded.
        for (int i = 1; i <= 4; i++) press("input", B_IN, 0, S_IV, S_NO, 0, 0, 3'(i), 0);
        press("submit no result", B_SU, 2'b00, S_CMP, S_NO, 0, 0, 4, 0);
        to_at = -1; iv_n = 0;
        for (int o = 7; o < 50; o++) begin
            if (o == 8) input_btn = 1'b1;
            if (o == 10) input_btn = 1'b0;
            step();
            if (input_value) iv_n++;
            if (input_reset && to_at < 0) to_at = o;
        end
        check("timeout input_reset offset", 16'(to_at), 16'(3 + RT));
        check("press during CHECK discarded", 16'(iv_n), 16'd0);
        check("after timeout levels", 16'(levels()), 16'({1'b0, 1'b0, 3'd0, 2'd1}));

        // Reset in the middle of SLEEP.
        press("short submit", B_SU, 0, S_IR, S_NO, 0, 0, 0, 2);
        press("short submit -> sleep", B_SU, 0, S_IR, S_NO, 0, 1, 0, 3);
        repeat (7) step();
        check("still sleeping before reset", 16'(sleep), 16'd1);
        system_reset = 1'b1;
        #1;
        check("async reset clears sleep", 16'(sleep), 16'd0);
        step();
        check("reset mid-sleep levels", 16'(levels()), 16'(7'd0));
        system_reset = 1'b0;
        es_at = 0; sleep_n = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (end_sleep) es_at++;
            if (sleep) sleep_n++;
        end
        check("no end_sleep after reset", 16'(es_at), 16'd0);
        check("no sleep after reset", 16'(sleep_n), 16'd0);
        press("store after reset (SET)", B_ST, 0, S_ST, S_NO, 0, 0, 1, 0);

        // Random stimulus against the reference model.
        system_reset = 1'b1;
        step();
        step();
        system_reset = 1'b0;
        model_reset();
        rb = 3'b000;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) rb[0] = ~rb[0];
            if ($urandom_range(0, 4) == 0) rb[1] = ~rb[1];
            if ($urandom_range(0, 15) == 0) rb[2] = ~rb[2];
            rr[0] = ($urandom_range(0, 5) == 0);
            rr[1] = ($urandom_range(0, 7) == 0);
            {submit_btn, input_btn, store_btn} = rb;
            {incorrect_password, correct_password} = rr;
            step();
            model_edge(rb, rr);
            check("random", 16'({strobes(), levels()}),
                  16'({m_str, m_mode == M_OPEN, m_mode == M_SLEEP, 3'(m_sym), 2'(m_fail)}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 The block SHALL run on one clock with an asynchronous, active-high reset; the clock port SHALL be named clk and the reset port system_reset.
REQ-002 The block SHALL expose these parameters (name, default, meaning):
- PW_LEN, 4, symbols per password.
- MAX_FAILS, 3, consecutive failures before lockout.
- SLEEP_CYCLES, 250000000, lockout duration in clk cycles.
- RESULT_TIMEOUT, 16, cycles to wait for a compare result.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock.
- system_reset  in  1  async active-high reset.
- store_btn  in  1  raw store request, active-high.
- input_btn  in  1  raw entry request, active-high.
- submit_btn  in  1  raw submit request, active-high.
- correct_password  in  1  checker result, match.
- incorrect_password  in  1  checker result, mismatch.
- store_value  out  1  1-cycle strobe, latch symbol into system register.
- input_value  out  1  1-cycle strobe, latch symbol into input register.
- compare  out  1  1-cycle strobe, start comparison.
- input_reset  out  1  1-cycle strobe, clear input register.
- sys_clear  out  1  1-cycle strobe, clear system register.
- unlock  out  1  level, lock open.
- sleep  out  1  level, lockout active.
- end_sleep  out  1  1-cycle strobe at lockout expiry.
- sym_count  out  3  symbols stored or entered in the current state.
- fail_count  out  2  consecutive failures.

Function
REQ-004 Each button SHALL pass through a 2-flop synchronizer and rising-edge detector, giving one press event per low-to-high transition; held levels SHALL NOT repeat.
REQ-005 Every strobe SHALL be registered and SHALL assert exactly 3 clk cycles after the button is first sampled high, for exactly 1 cycle.
REQ-006 States SHALL be SET, LOCKED, CHECK, OPEN and SLEEP; the state after reset SHALL be SET.
REQ-007 In SET, a store press SHALL pulse store_value and increment sym_count; when sym_count reaches PW_LEN, the block SHALL go to LOCKED and clear sym_count; input and submit presses SHALL be ignored.
REQ-008 In LOCKED, an input press with sym_count<PW_LEN SHALL pulse input_value and increment sym_count; an input press at PW_LEN SHALL be ignored; store presses SHALL be ignored.
REQ-009 In LOCKED, a submit press with sym_count==PW_LEN SHALL pulse compare and go to CHECK; a submit press with sym_count<PW_LEN SHALL be a failure (REQ-011) without a compare pulse.
REQ-010 In CHECK, correct_password high SHALL cause: go to OPEN, fail_count=0, pulse input_reset, sym_count=0.
REQ-011 In CHECK, a failure SHALL be incorrect_password high, both results high together, or RESULT_TIMEOUT cycles with neither. A failure SHALL increment fail_count, pulse input_reset and clear sym_count, then go to SLEEP if fail_count reaches MAX_FAILS, else to LOCKED.
REQ-012 Presses arriving during CHECK SHALL be discarded.
REQ-013 In OPEN, unlock SHALL be 1. A submit press SHALL pulse input_reset and go to LOCKED. A store press SHALL pulse sys_clear, clear sym_count and go to SET.
REQ-014 In SLEEP, sleep SHALL be 1, all presses SHALL be ignored, and a timer SHALL count SLEEP_CYCLES. On expiry the block SHALL pulse end_sleep, clear fail_count and go to LOCKED.
REQ-015 Simultaneous press events SHALL be resolved by priority submit > input > store; lower-priority events in that cycle SHALL be dropped.
REQ-016 At most one of store_value, input_value, compare, input_reset and sys_clear SHALL be high in any cycle.
REQ-017 fail_count SHALL saturate at MAX_FAILS, and the timer SHALL be wide enough for SLEEP_CYCLES without wrap.

Reset
REQ-018 Reset SHALL clear all strobes, unlock, sleep, sym_count, fail_count, the timer and the synchronizers, and SHALL force state SET.
REQ-019 Reset asserted in any state, including mid-SLEEP or mid-CHECK, SHALL abort the operation immediately with no end_sleep pulse.

Structure
REQ-020 The state encoding and default parameter constants SHALL live in a shared package lock_pkg.
REQ-021 One sub-module, btn_edge (synchronizer plus rising-edge pulse), SHALL be instantiated once per button.

Verification (PW_LEN=4, MAX_FAILS=3, SLEEP_CYCLES=20, RESULT_TIMEOUT=16)
REQ-022 The bench SHALL cover these directed scenarios:
- 4 store presses -> 4 store_value pulses, each 3 cycles after its press; state LOCKED; sym_count=0.
- 4 input presses, submit, correct_password high one cycle later -> compare pulse, then unlock=1, fail_count=0.
- 3 submits each answered by incorrect_password -> fail_count 1, 2, 3; sleep=1 for 20 cycles; end_sleep pulse; fail_count=0.
- Submit after 2 inputs -> no compare pulse, input_reset pulse, fail_count=1; 5th input press in LOCKED -> no input_value pulse.
- Compare with no result for 16 cycles -> treated as failure; both results high together -> failure.
- Reset asserted at cycle 10 of SLEEP -> sleep=0 next cycle, state SET, no end_sleep pulse; submit and input pressed in the same cycle -> only the submit action occurs.
